dmem_bus_mux: RTL and testbench
===============================

DMEM_BUS_MUX -- requirements
Module: dmem_bus_mux

Interface
REQ-001 SHALL have parameter NSLV, default 4, number of slave regions (1..8).
REQ-002 SHALL have parameter DATA_W, default 32, data width (multiple of 8).
REQ-003 SHALL have parameter MATCH_HI, default 16, number of upper address bits compared for region match.
REQ-004 SHALL have parameter SLV_BASE, default {16'hFFFF,16'h0002,16'h0001,16'h0000}, NSLV x MATCH_HI packed, slot i = region i base.
REQ-005 SHALL have parameter TIMEOUT, default 255, max cycles waiting for s_ready (1..65535).
REQ-006 clk  in  1  sole clock, all state on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-low.
REQ-008 m_req  in  1  master access request, sampled in IDLE.
REQ-009 m_we  in  1  1 = write, 0 = read.
REQ-010 m_wstrb  in  DATA_W/8  byte write strobes.
REQ-011 m_addr  in  32  byte address.
REQ-012 m_wdata  in  DATA_W  write data.
REQ-013 m_ready  out  1  one-cycle completion pulse.
REQ-014 m_rdata  out  DATA_W  read data, valid while m_ready=1.
REQ-015 m_err  out  1  error flag, valid while m_ready=1.
REQ-016 m_busy  out  1  high whenever state != IDLE.
REQ-017 s_sel  out  NSLV  one-hot slave select.
REQ-018 s_we, s_wstrb, s_addr, s_wdata  out  1/DATA_W/8/32/DATA_W  latched request broadcast to all slaves.
REQ-019 s_rdata  in  NSLV*DATA_W  per-slave read data, slot i at [i*DATA_W +: DATA_W].
REQ-020 s_ready  in  NSLV  per-slave completion.
REQ-021 err_irq  out  1  one-cycle pulse on any errored transaction.
REQ-022 err_addr  out  32  address of most recent errored transaction.
REQ-023 err_cnt  out  8  errored-transaction count, saturating at 255.

Function
REQ-024 FSM SHALL have states IDLE, ACCESS, RESP only.
REQ-025 IDLE with m_req=1: latch m_we/m_wstrb/m_addr/m_wdata, decode, go ACCESS if region matched, else RESP with error.
REQ-026 Region i matches when m_addr[31:32-MATCH_HI] equals slot i of SLV_BASE; multiple matches: lowest index wins.
REQ-027 ACCESS: s_sel one-hot on matched index, s_* held at latched values, timeout counter increments each cycle.
REQ-028 ACCESS with s_ready[sel]=1: capture s_rdata slot sel (reads; 0 for writes), go RESP, no error; s_ready of unselected slaves ignored.
REQ-029 ACCESS with counter = TIMEOUT-1 and no s_ready[sel]: go RESP with error; s_sel deasserted in RESP.
REQ-030 RESP: m_ready=1 for exactly one cycle, m_rdata = captured data (0 on error), m_err = error flag; then IDLE.
REQ-031 m_req SHALL be ignored in ACCESS and RESP; master may drop m_req after acceptance; m_req high in the IDLE cycle after RESP starts a new transaction.
REQ-032 Latency: req accepted cycle 0; s_sel high from cycle 1; s_ready at cycle k (k>=1) -> m_ready at k+1; minimum 2 cycles.
REQ-033 Unmapped access: no s_sel assertion, m_ready+m_err at cycle 1.
REQ-034 On error in RESP: err_irq=1 same cycle as m_ready, err_addr <= latched address, err_cnt += 1 unless 255.
REQ-035 s_sel, m_ready, err_irq outputs SHALL be registered (no combinational path from m_* or s_ready).
REQ-036 m_wstrb=0 write is a normal access forwarded unchanged.
REQ-037 s_ready arriving after timeout SHALL be ignored, no effect on subsequent transaction.

Reset
REQ-038 rst=0 at clk edge: state IDLE; m_ready, m_err, m_busy, s_sel, err_irq, m_rdata, err_addr, err_cnt, timeout counter all 0; latched request 0.
REQ-039 Reset mid-ACCESS: s_sel 0 after that edge, transaction abandoned, no m_ready issued.

Verification
REQ-040 Read 0x0001_0008, slave1 s_ready same cycle as s_sel, s_rdata slot1=0xDEADBEEF -> s_sel=4'b0010 cycle 1, m_ready cycle 2, m_rdata=0xDEADBEEF, m_err=0.
REQ-041 Write 0x0000_0004 wstrb=4'b0011 wdata=0x1234ABCD, slave0 ready after 3 wait cycles -> s_wstrb=4'b0011 held 4 cycles, m_ready cycle 5, m_err=0.
REQ-042 Access 0x0005_0000 -> no s_sel, m_ready+m_err+err_irq cycle 1, err_addr=0x0005_0000, err_cnt=1.
REQ-043 TIMEOUT=4, slave3 never ready on 0xFFFF_0010 -> s_sel high cycles 1-4, m_err pulse cycle 5, m_rdata=0; s_ready[3] at cycle 6 ignored.
REQ-044 256 unmapped accesses -> err_cnt=255 and stays; rst=0 during ACCESS -> s_sel=0 next cycle, no m_ready.

Source files
------------

// File: rtl/dmem_bus_mux.sv
// Data-memory bus mux: routes one master access to the slave region that owns
// the upper address bits, with per-access timeout and an error log.

module dmem_bus_mux_slot #(
    parameter int                  DATA_W   = 32,
    parameter int                  MATCH_HI = 16,
    parameter logic [MATCH_HI-1:0] BASE     = '0
) (
    input  logic [31:0]       addr,
    input  logic              sel,
    input  logic [DATA_W-1:0] rdata,
    output logic              hit,
    output logic [DATA_W-1:0] rdata_m
);
    assign hit     = (addr[31 -: MATCH_HI] == BASE);
    assign rdata_m = sel ? rdata : '0;
endmodule

module dmem_bus_mux #(
    parameter int                       NSLV     = 4,
    parameter int                       DATA_W   = 32,
    parameter int                       MATCH_HI = 16,
    parameter logic [NSLV*MATCH_HI-1:0] SLV_BASE = {16'hFFFF, 16'h0002, 16'h0001, 16'h0000},
    parameter int                       TIMEOUT  = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   m_req,
    input  logic                   m_we,
    input  logic [DATA_W/8-1:0]    m_wstrb,
    input  logic [31:0]            m_addr,
    input  logic [DATA_W-1:0]      m_wdata,
    output logic                   m_ready,
    output logic [DATA_W-1:0]      m_rdata,
    output logic                   m_err,
    output logic                   m_busy,
    output logic [NSLV-1:0]        s_sel,
    output logic                   s_we,
    output logic [DATA_W/8-1:0]    s_wstrb,
    output logic [31:0]            s_addr,
    output logic [DATA_W-1:0]      s_wdata,
    input  logic [NSLV*DATA_W-1:0] s_rdata,
    input  logic [NSLV-1:0]        s_ready,
    output logic                   err_irq,
    output logic [31:0]            err_addr,
    output logic [7:0]             err_cnt
);
    localparam int          SW      = DATA_W / 8;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef struct packed {
        logic              we;
        logic [SW-1:0]     wstrb;
        logic [31:0]       addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t                       state, state_nxt;
    req_t                         req_q, req_nxt;
    logic [NSLV-1:0]              match, hit_oh, sel_nxt;
    logic [NSLV-1:0][DATA_W-1:0]  slot_rd;
    logic [DATA_W-1:0]            sel_rdata, rdata_nxt;
    logic [15:0]                  tcnt, tcnt_nxt;
    logic                         rdy_nxt, err_nxt, found;

    for (genvar i = 0; i < NSLV; i++) begin : g_slot
        dmem_bus_mux_slot #(
            .DATA_W  (DATA_W),
            .MATCH_HI(MATCH_HI),
            .BASE    (SLV_BASE[i*MATCH_HI +: MATCH_HI])
        ) u_slot (
            .addr   (m_addr),
            .sel    (s_sel[i]),
            .rdata  (s_rdata[i*DATA_W +: DATA_W]),
            .hit    (match[i]),
            .rdata_m(slot_rd[i])
        );
    end

    // Lowest matching region wins when bases overlap.
    always_comb begin
        hit_oh    = '0;
        found     = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (match[i] && !found) begin
                hit_oh[i] = 1'b1;
                found     = 1'b1;
            end
            sel_rdata = sel_rdata | slot_rd[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_nxt   = req_q;
        sel_nxt   = '0;
        tcnt_nxt  = '0;
        rdata_nxt = '0;
        rdy_nxt   = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (m_req) begin
                    req_nxt = '{we: m_we, wstrb: m_wstrb, addr: m_addr, wdata: m_wdata};
                    if (found) begin
                        state_nxt = ACCESS;
                        sel_nxt   = hit_oh;
                    end else begin
                        state_nxt = RESP;
                        rdy_nxt   = 1'b1;
                        err_nxt   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // A ready in the last allowed cycle still completes normally.
                if (|(s_ready & s_sel)) begin
                    state_nxt = RESP;
                    rdy_nxt   = 1'b1;
                    rdata_nxt = req_q.we ? '0 : sel_rdata;
                end else if (tcnt == TO_LAST) begin
                    state_nxt = RESP;
                    rdy_nxt   = 1'b1;
                    err_nxt   = 1'b1;
                end else begin
                    sel_nxt  = s_sel;
                    tcnt_nxt = tcnt + 16'd1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            req_q    <= '0;
            s_sel    <= '0;
            tcnt     <= '0;
            m_ready  <= 1'b0;
            m_err    <= 1'b0;
            err_irq  <= 1'b0;
            m_rdata  <= '0;
            err_addr <= '0;
            err_cnt  <= '0;
        end else begin
            req_q   <= req_nxt;
            s_sel   <= sel_nxt;
            tcnt    <= tcnt_nxt;
            m_ready <= rdy_nxt;
            m_err   <= err_nxt;
            err_irq <= err_nxt;
            m_rdata <= rdata_nxt;
            if (state == RESP && m_err) begin
                err_addr <= req_q.addr;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    assign m_busy  = (state != IDLE);
    assign s_we    = req_q.we;
    assign s_wstrb = req_q.wstrb;
    assign s_addr  = req_q.addr;
    assign s_wdata = req_q.wdata;
endmodule

// File: tb/tb_dmem_bus_mux.sv
// Bench for dmem_bus_mux: directed vector table, randomized traffic against a
// region/latency model, error-counter saturation and reset mid-access.

module tb_dmem_bus_mux;
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         m_req = 1'b0, m_we = 1'b0;
    logic [3:0]   m_wstrb = '0;
    logic [31:0]  m_addr = '0, m_wdata = '0;
    logic         m_ready, m_err, m_busy, s_we, err_irq;
    logic [31:0]  m_rdata, s_addr, s_wdata, err_addr;
    logic [3:0]   s_sel, s_wstrb;
    logic [127:0] s_rdata = '0;
    logic [3:0]   s_ready = '0;
    logic [7:0]   err_cnt;

    dmem_bus_mux #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata),
        .m_err(m_err), .m_busy(m_busy), .s_sel(s_sel), .s_we(s_we),
        .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .s_ready(s_ready), .err_irq(err_irq), .err_addr(err_addr), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        int          wait_n;
        logic [3:0]  pre_rdy;
        logic [31:0] slot_rd;
        int          tgt;
        int          lat;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    int          n_chk = 0, n_pass = 0;
    logic [7:0]  mdl_cnt = '0;
    logic [31:0] mdl_addr = '0;
    logic [15:0] bases [4] = '{16'h0000, 16'h0001, 16'h0002, 16'hFFFF};
    vec_t        tbl [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    function automatic int region(input logic [31:0] a);
        for (int i = 0; i < 4; i++)
            if (a[31:16] == bases[i]) return i;
        return -1;
    endfunction

    // Expected outcome from the address map and the slave's wait count.
    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [3:0] wstrb,
                                input logic [31:0] wdata, input int wait_n, input logic [3:0] pre,
                                input logic [31:0] rd);
        vec_t v;
        v.name = "rand"; v.we = we; v.addr = addr; v.wstrb = wstrb; v.wdata = wdata;
        v.wait_n = wait_n; v.pre_rdy = pre; v.slot_rd = rd;
        v.tgt = region(addr);
        if (v.tgt < 0)          begin v.lat = 1;          v.err = 1'b1; end
        else if (wait_n < TO)   begin v.lat = wait_n + 2; v.err = 1'b0; end
        else                    begin v.lat = TO + 1;     v.err = 1'b1; end
        v.rd = (v.err || we) ? 32'h0 : rd;
        return v;
    endfunction

    task automatic run_txn(input vec_t v);
        logic [3:0]  exp_sel;
        logic        sel_ok, hold_ok, rdy_ok;
        logic [31:0] noise;
        exp_sel = (v.tgt >= 0) ? 4'(1 << v.tgt) : 4'b0;
        @(negedge clk);
        chk({v.name, ":idle_busy"}, 32'(m_busy), 32'h0);
        chk({v.name, ":err_cnt"}, 32'(err_cnt), 32'(mdl_cnt));
        chk({v.name, ":err_addr"}, err_addr, mdl_addr);
        for (int i = 0; i < 4; i++) s_rdata[i*32 +: 32] = $urandom;
        if (v.tgt >= 0) s_rdata[v.tgt*32 +: 32] = v.slot_rd;
        m_req = 1'b1; m_we = v.we; m_addr = v.addr; m_wstrb = v.wstrb; m_wdata = v.wdata;
        s_ready = v.pre_rdy;
        sel_ok = 1'b1; hold_ok = 1'b1; rdy_ok = 1'b1;
        for (int c = 1; c <= v.lat; c++) begin
            @(negedge clk);
            if (c == 1) begin
                m_req = 1'b0; m_addr = $urandom; m_wdata = $urandom;
                m_we = ~v.we; m_wstrb = ~v.wstrb;
            end
            if (s_sel !== ((c < v.lat) ? exp_sel : 4'b0)) sel_ok = 1'b0;
            if (c < v.lat && v.tgt >= 0 &&
                (s_we !== v.we || s_addr !== v.addr || s_wstrb !== v.wstrb || s_wdata !== v.wdata))
                hold_ok = 1'b0;
            if (m_ready !== (c == v.lat)) rdy_ok = 1'b0;
            if (c == v.lat) begin
                chk({v.name, ":m_err"}, 32'(m_err), 32'(v.err));
                chk({v.name, ":m_rdata"}, m_rdata, v.rd);
                chk({v.name, ":err_irq"}, 32'(err_irq), 32'(v.err));
                chk({v.name, ":resp_busy"}, 32'(m_busy), 32'h1);
            end
            noise   = $urandom;
            s_ready = noise[3:0] & ~exp_sel;
            if (c == v.wait_n + 1) s_ready = s_ready | exp_sel;
        end
        chk({v.name, ":sel_trace"}, 32'(sel_ok), 32'h1);
        chk({v.name, ":ready_timing"}, 32'(rdy_ok), 32'h1);
        if (v.tgt >= 0) chk({v.name, ":bus_hold"}, 32'(hold_ok), 32'h1);
        if (v.err) begin
            mdl_addr = v.addr;
            if (mdl_cnt != 8'hFF) mdl_cnt = mdl_cnt + 8'd1;
        end
    endtask

    initial begin
        logic [31:0] r;
        vec_t        v;
        logic        saw_rdy;
        int          pick;

        //           name              we  addr          strb  wdata         wt pre    slot_rd       tgt lat err rd
        tbl[0] = '{"rd_s1_fast",      1'b0, 32'h0001_0008, 4'hF, 32'h0,        0, 4'h0, 32'hDEADBEEF,  1, 2, 1'b0, 32'hDEADBEEF};
        tbl[1] = '{"wr_s0_wait3",     1'b1, 32'h0000_0004, 4'h3, 32'h1234ABCD, 3, 4'h0, 32'hCAFEF00D,  0, 5, 1'b0, 32'h0};
        tbl[2] = '{"unmapped",        1'b0, 32'h0005_0000, 4'hF, 32'h0,        0, 4'h0, 32'h0,        -1, 1, 1'b1, 32'h0};
        tbl[3] = '{"timeout_s3",      1'b0, 32'hFFFF_0010, 4'hF, 32'h0,        5, 4'h0, 32'h11112222,  3, 5, 1'b1, 32'h0};
        tbl[4] = '{"stray_late_rdy",  1'b0, 32'h0002_0000, 4'hF, 32'h0,        1, 4'h8, 32'hA5A50002,  2, 3, 1'b0, 32'hA5A50002};
        tbl[5] = '{"wr_zero_strb",    1'b1, 32'hFFFF_FFFC, 4'h0, 32'h89ABCDEF, 0, 4'h0, 32'h0,         3, 2, 1'b0, 32'h0};
        tbl[6] = '{"rdy_last_cycle",  1'b0, 32'h0001_FFFF, 4'hF, 32'h0,        3, 4'h0, 32'h55AA55AA,  1, 5, 1'b0, 32'h55AA55AA};
        tbl[7] = '{"unmapped_wr",     1'b1, 32'h0003_0000, 4'h1, 32'hFFFFFFFF, 0, 4'h0, 32'h0,        -1, 1, 1'b1, 32'h0};
        tbl[8] = '{"rd_s0_wait2",     1'b0, 32'h0000_0000, 4'hF, 32'h0,        2, 4'h0, 32'h0BADC0DE,  0, 4, 1'b0, 32'h0BADC0DE};

        // Reset held with a live request: nothing may start.
        m_req = 1'b1; m_addr = 32'h0001_0000; m_wdata = 32'hFFFF_FFFF; m_we = 1'b1; m_wstrb = 4'hF;
        @(negedge clk); @(negedge clk);
        chk("rst:m_ready", 32'(m_ready), 32'h0);
        chk("rst:m_err", 32'(m_err), 32'h0);
        chk("rst:m_busy", 32'(m_busy), 32'h0);
        chk("rst:s_sel", 32'(s_sel), 32'h0);
        chk("rst:err_irq", 32'(err_irq), 32'h0);
        chk("rst:m_rdata", m_rdata, 32'h0);
        chk("rst:err_addr", err_addr, 32'h0);
        chk("rst:err_cnt", 32'(err_cnt), 32'h0);
        chk("rst:s_bus", {s_addr ^ s_wdata, 27'h0, s_we, s_wstrb}, 32'h0);
        m_req = 1'b0; rst = 1'b1;

        for (int i = 0; i < 9; i++) run_txn(tbl[i]);

        for (int i = 0; i < 40; i++) begin
            r    = $urandom;
            pick = $urandom_range(0, 4);
            if (pick < 4) r[31:16] = bases[pick];
            else          r[31:16] = 16'h0003 + 16'($urandom_range(0, 200));
            v = mk(1'($urandom), r, 4'($urandom), $urandom, $urandom_range(0, 6),
                   4'($urandom), $urandom);
            run_txn(v);
        end

        // Error counter must stick at 255.
        for (int i = 0; i < 256; i++) begin
            v = mk(1'b0, {16'h0100 + 16'(i), 16'($urandom)}, 4'hF, 32'h0, 0, 4'h0, 32'h0);
            run_txn(v);
        end
        @(negedge clk);
        s_ready = '0;
        chk("sat:err_cnt", 32'(err_cnt), 32'hFF);
        chk("sat:err_addr", err_addr, mdl_addr);

        // Reset during ACCESS abandons the access silently.
        @(negedge clk);
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0002_0040; m_wstrb = 4'hF;
        @(negedge clk);
        m_req = 1'b0;
        chk("midrst:sel_before", 32'(s_sel), 32'h4);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst:s_sel", 32'(s_sel), 32'h0);
        chk("midrst:m_busy", 32'(m_busy), 32'h0);
        chk("midrst:m_ready", 32'(m_ready), 32'h0);
        chk("midrst:err_cnt", 32'(err_cnt), 32'h0);
        rst = 1'b1;
        s_ready = 4'hF;
        saw_rdy = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (m_ready) saw_rdy = 1'b1;
            s_ready = '0;
        end
        chk("midrst:no_ready", 32'(saw_rdy), 32'h0);
        mdl_cnt = '0; mdl_addr = '0;
        run_txn(tbl[0]);
        run_txn(tbl[2]);
        @(negedge clk);
        s_ready = '0;
        chk("final:err_cnt", 32'(err_cnt), 32'(mdl_cnt));
        chk("final:err_addr", err_addr, mdl_addr);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
